alu_share_arbiter: RTL and testbench

Shares one combinational alu32 instance between two requesters, e.g. the integer issue path (port 0) and the branch/address unit (port 1). Round-robin arbitration with valid/ready handshakes on both sides. The selected request is driven onto the ALU and its result is captured into a one-entry response register, tagged with the owning requester. Sits between the decode/issue logic and the shared ALU in the Mini-MIPS datapath.

---
 rtl/alu_share_arbiter.sv | 154 +++++++++++++++
 tb/tb_alu_share_arbiter.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_share_arbiter.sv
// alu_share_arbiter
// Shares one combinational ALU between two requesters with round-robin
// arbitration and a one-entry response register tagged with its owner.
//
// Handshake rule (both request and response sides): a transfer happens on a
// rising clk edge where valid && ready are both high. Ready never depends on
// the valid of the same port. Once valid is raised it is expected to hold
// its payload until the transfer.
module alu_share_arbiter #(
   parameter int DW         = 32,
   parameter bit PRIO_RESET = 1'b0,
   parameter int CNT_W      = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   // requester 0
   input  logic             r0_valid,
   output logic             r0_ready,
   input  logic [5:0]       r0_opcode,
   input  logic [5:0]       r0_funct,
   input  logic [DW-1:0]    r0_rs1,
   input  logic [DW-1:0]    r0_rs2,
   // requester 1
   input  logic             r1_valid,
   output logic             r1_ready,
   input  logic [5:0]       r1_opcode,
   input  logic [5:0]       r1_funct,
   input  logic [DW-1:0]    r1_rs1,
   input  logic [DW-1:0]    r1_rs2,
   // shared ALU
   output logic [5:0]       alu_opcode,
   output logic [5:0]       alu_funct,
   output logic [DW-1:0]    alu_rs1,
   output logic [DW-1:0]    alu_rs2,
   input  logic [DW-1:0]    alu_result,
   input  logic             alu_zero,
   input  logic             alu_ovf,
   // responses
   output logic             rsp0_valid,
   input  logic             rsp0_ready,
   output logic             rsp1_valid,
   input  logic             rsp1_ready,
   output logic [DW-1:0]    rsp_result,
   output logic             rsp_zero,
   output logic             rsp_ovf,
   output logic [CNT_W-1:0] op_count,
   // debug: 1 while a response is held (FULL), 0 when EMPTY
   output logic             o_dbg_state
);

   typedef enum logic {
      S_EMPTY = 1'b0,
      S_FULL  = 1'b1
   } state_t;

   state_t            r_state;
   state_t            w_state_nxt;
   logic              r_owner;
   logic              r_prio;
   logic [DW-1:0]     r_result;
   logic              r_zero;
   logic              r_ovf;
   logic [CNT_W-1:0]  r_count;

   logic              w_consume;
   logic              w_can_accept;
   logic              w_xfer0;
   logic              w_xfer1;
   logic              w_xfer;

   // Arbitration: priority holder gets ready whenever a slot is free; the
   // other requester only when the priority holder is idle. Gated by rst_n
   // so nothing is accepted during a reset cycle.
   always_comb begin
      w_consume    = (r_state == S_FULL) && (r_owner ? rsp1_ready : rsp0_ready);
      w_can_accept = rst_n && ((r_state == S_EMPTY) || w_consume);
      if (r_prio == 1'b0) begin
         r0_ready = w_can_accept;
         r1_ready = w_can_accept && !r0_valid;
      end else begin
         r1_ready = w_can_accept;
         r0_ready = w_can_accept && !r1_valid;
      end
      w_xfer0 = r0_valid && r0_ready;
      w_xfer1 = r1_valid && r1_ready;
      w_xfer  = w_xfer0 || w_xfer1;
   end

   // ALU drive: granted requester's fields in a transfer cycle, else zeros.
   always_comb begin
      alu_opcode = '0;
      alu_funct  = '0;
      alu_rs1    = '0;
      alu_rs2    = '0;
      if (w_xfer0) begin
         alu_opcode = r0_opcode;
         alu_funct  = r0_funct;
         alu_rs1    = r0_rs1;
         alu_rs2    = r0_rs2;
      end else if (w_xfer1) begin
         alu_opcode = r1_opcode;
         alu_funct  = r1_funct;
         alu_rs1    = r1_rs1;
         alu_rs2    = r1_rs2;
      end
   end

   // Next-state logic and response-valid outputs.
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_EMPTY: if (w_xfer) w_state_nxt = S_FULL;
         S_FULL: begin
            if (w_xfer)         w_state_nxt = S_FULL;
            else if (w_consume) w_state_nxt = S_EMPTY;
         end
         default: w_state_nxt = S_EMPTY;
      endcase
      rsp0_valid  = (r_state == S_FULL) && !r_owner;
      rsp1_valid  = (r_state == S_FULL) &&  r_owner;
      o_dbg_state = (r_state == S_FULL);
   end

   // State register.
   always_ff @(posedge clk) begin
      if (!rst_n) r_state <= S_EMPTY;
      else        r_state <= w_state_nxt;
   end

   // Response capture, owner tag, round-robin pointer and accept counter.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_owner  <= 1'b0;
         r_prio   <= PRIO_RESET;
         r_result <= '0;
         r_zero   <= 1'b0;
         r_ovf    <= 1'b0;
         r_count  <= '0;
      end else if (w_xfer) begin
         r_owner  <= w_xfer1;
         r_prio   <= !w_xfer1;
         r_result <= alu_result;
         r_zero   <= alu_zero;
         r_ovf    <= alu_ovf;
         r_count  <= r_count + 1'b1;
      end
   end

   assign rsp_result = r_result;
   assign rsp_zero   = r_zero;
   assign rsp_ovf    = r_ovf;
   assign op_count   = r_count;

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Bench for alu_share_arbiter: directed scenarios followed by random traffic,
// all checked cycle by cycle against a transaction-level reference model.
// A stand-in ALU function drives alu_result/zero/ovf from the DUT's alu_*.
module tb_alu_share_arbiter;

   localparam int DW = 32;

   typedef struct {
      logic          v;
      logic [5:0]    op;
      logic [5:0]    fn;
      logic [DW-1:0] a;
      logic [DW-1:0] b;
   } req_t;

   // clock / reset
   logic clk = 1'b0;
   always #5 clk = ~clk;
   logic rst_n;

   // stimulus
   logic          r0_valid, r1_valid, rsp0_ready, rsp1_ready;
   logic [5:0]    r0_opcode, r0_funct, r1_opcode, r1_funct;
   logic [DW-1:0] r0_rs1, r0_rs2, r1_rs1, r1_rs2;

   // main DUT outputs
   logic          r0_ready, r1_ready, rsp0_valid, rsp1_valid, rsp_zero, rsp_ovf, dbg_state;
   logic [5:0]    alu_opcode, alu_funct;
   logic [DW-1:0] alu_rs1, alu_rs2, alu_result, rsp_result;
   logic          alu_zero, alu_ovf;
   logic [15:0]   op_count;

   // narrow-counter DUT outputs
   logic          c2_r0_ready, c2_r1_ready, c2_rsp0_valid, c2_rsp1_valid, c2_rsp_zero, c2_rsp_ovf, c2_dbg;
   logic [5:0]    c2_alu_opcode, c2_alu_funct;
   logic [DW-1:0] c2_alu_rs1, c2_alu_rs2, c2_alu_result, c2_rsp_result;
   logic          c2_alu_zero, c2_alu_ovf;
   logic [1:0]    c2_op_count;

   // Stand-in ALU: returns {ovf, zero, result}.
   function automatic logic [DW+1:0] alu_fn(input logic [5:0] op, input logic [5:0] fn,
                                            input logic [DW-1:0] a, input logic [DW-1:0] b);
      logic [DW-1:0] r;
      logic          ovf;
      logic          is_sub;
      is_sub = (op == 6'h09) || (op == 6'h00 && fn == 6'h22);
      ovf    = 1'b0;
      if (op == 6'h00 && fn == 6'h24)      r = a & b;
      else if (op == 6'h00 && fn == 6'h25) r = a | b;
      else if (is_sub) begin
         r   = a - b;
         ovf = (a[DW-1] != b[DW-1]) && (r[DW-1] != a[DW-1]);
      end else begin
         r   = a + b;
         ovf = (a[DW-1] == b[DW-1]) && (r[DW-1] != a[DW-1]);
      end
      return {ovf, (r == '0), r};
   endfunction

   always_comb {alu_ovf, alu_zero, alu_result} = alu_fn(alu_opcode, alu_funct, alu_rs1, alu_rs2);
   always_comb {c2_alu_ovf, c2_alu_zero, c2_alu_result} =
      alu_fn(c2_alu_opcode, c2_alu_funct, c2_alu_rs1, c2_alu_rs2);

   alu_share_arbiter #(.DW(DW), .PRIO_RESET(1'b0), .CNT_W(16)) dut (
      .clk(clk), .rst_n(rst_n),
      .r0_valid(r0_valid), .r0_ready(r0_ready), .r0_opcode(r0_opcode), .r0_funct(r0_funct),
      .r0_rs1(r0_rs1), .r0_rs2(r0_rs2),
      .r1_valid(r1_valid), .r1_ready(r1_ready), .r1_opcode(r1_opcode), .r1_funct(r1_funct),
      .r1_rs1(r1_rs1), .r1_rs2(r1_rs2),
      .alu_opcode(alu_opcode), .alu_funct(alu_funct), .alu_rs1(alu_rs1), .alu_rs2(alu_rs2),
      .alu_result(alu_result), .alu_zero(alu_zero), .alu_ovf(alu_ovf),
      .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready),
      .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready),
      .rsp_result(rsp_result), .rsp_zero(rsp_zero), .rsp_ovf(rsp_ovf),
      .op_count(op_count), .o_dbg_state(dbg_state)
   );

   alu_share_arbiter #(.DW(DW), .PRIO_RESET(1'b0), .CNT_W(2)) dut_c2 (
      .clk(clk), .rst_n(rst_n),
      .r0_valid(r0_valid), .r0_ready(c2_r0_ready), .r0_opcode(r0_opcode), .r0_funct(r0_funct),
      .r0_rs1(r0_rs1), .r0_rs2(r0_rs2),
      .r1_valid(r1_valid), .r1_ready(c2_r1_ready), .r1_opcode(r1_opcode), .r1_funct(r1_funct),
      .r1_rs1(r1_rs1), .r1_rs2(r1_rs2),
      .alu_opcode(c2_alu_opcode), .alu_funct(c2_alu_funct), .alu_rs1(c2_alu_rs1), .alu_rs2(c2_alu_rs2),
      .alu_result(c2_alu_result), .alu_zero(c2_alu_zero), .alu_ovf(c2_alu_ovf),
      .rsp0_valid(c2_rsp0_valid), .rsp0_ready(rsp0_ready),
      .rsp1_valid(c2_rsp1_valid), .rsp1_ready(rsp1_ready),
      .rsp_result(c2_rsp_result), .rsp_zero(c2_rsp_zero), .rsp_ovf(c2_rsp_ovf),
      .op_count(c2_op_count), .o_dbg_state(c2_dbg)
   );

   // scoreboard bookkeeping
   int n_vec = 0;
   int n_err = 0;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // Reference model: one held response slot with an owner, a priority
   // pointer and an accepted-operation count.
   logic          m_known = 1'b0;
   logic          m_full, m_owner, m_prio, m_zero, m_ovf;
   logic [DW-1:0] m_res;
   int unsigned   m_cnt;
   logic [DW-1:0] exp_q[$];   // results of accepted requests, in order

   localparam req_t IDLE = '{v: 1'b0, op: 6'h0, fn: 6'h0, a: '0, b: '0};

   function automatic req_t mk(input logic [5:0] op, input logic [5:0] fn,
                               input logic [DW-1:0] a, input logic [DW-1:0] b);
      req_t q;
      q.v = 1'b1; q.op = op; q.fn = fn; q.a = a; q.b = b;
      return q;
   endfunction

   // Driver: one clock cycle with the given inputs, checking every output.
   task automatic step(input logic rst, input req_t q0, input req_t q1,
                       input logic rr0, input logic rr1);
      logic          can, rdy0, rdy1;
      int            g;
      req_t          gq;
      logic [DW+1:0] ar;
      @(negedge clk);
      if (m_known) begin
         chk("rsp0_valid", rsp0_valid, m_full && !m_owner);
         chk("rsp1_valid", rsp1_valid, m_full && m_owner);
         chk("rsp_result", rsp_result, m_res);
         chk("rsp_zero",   rsp_zero,   m_zero);
         chk("rsp_ovf",    rsp_ovf,    m_ovf);
         chk("op_count",   op_count,   m_cnt % 65536);
         chk("op_count_w2", c2_op_count, m_cnt % 4);
         chk("dbg_state",  dbg_state,  m_full);
      end
      rst_n = rst;
      r0_valid = q0.v; r0_opcode = q0.op; r0_funct = q0.fn; r0_rs1 = q0.a; r0_rs2 = q0.b;
      r1_valid = q1.v; r1_opcode = q1.op; r1_funct = q1.fn; r1_rs1 = q1.a; r1_rs2 = q1.b;
      rsp0_ready = rr0; rsp1_ready = rr1;
      #1;
      can = rst && (!m_full || (m_owner ? rr1 : rr0));
      rdy0 = (m_prio == 1'b0) ? can : (can && !q1.v);
      rdy1 = (m_prio == 1'b1) ? can : (can && !q0.v);
      g  = -1;
      gq = IDLE;
      if (q0.v && rdy0)      begin g = 0; gq = q0; end
      else if (q1.v && rdy1) begin g = 1; gq = q1; end
      if (m_known) begin
         chk("r0_ready",   r0_ready,   rdy0);
         chk("r1_ready",   r1_ready,   rdy1);
         chk("alu_opcode", alu_opcode, (g >= 0) ? gq.op : 6'h0);
         chk("alu_funct",  alu_funct,  (g >= 0) ? gq.fn : 6'h0);
         chk("alu_rs1",    alu_rs1,    (g >= 0) ? gq.a  : '0);
         chk("alu_rs2",    alu_rs2,    (g >= 0) ? gq.b  : '0);
      end
      @(posedge clk);
      if (!rst) begin
         m_known = 1'b1;
         m_full = 1'b0; m_owner = 1'b0; m_prio = 1'b0;
         m_res = '0; m_zero = 1'b0; m_ovf = 1'b0; m_cnt = 0;
         exp_q.delete();
      end else if (g >= 0) begin
         ar = alu_fn(gq.op, gq.fn, gq.a, gq.b);
         {m_ovf, m_zero, m_res} = ar;
         exp_q.push_back(ar[DW-1:0]);
         m_full  = 1'b1;
         m_owner = (g == 1);
         m_prio  = (g == 0);
         m_cnt++;
      end else if (m_full && (m_owner ? rr1 : rr0)) begin
         m_full = 1'b0;
      end
   endtask

   task automatic do_reset(input int cycles);
      for (int i = 0; i < cycles; i++) step(1'b0, IDLE, IDLE, 1'b0, 1'b0);
   endtask

   function automatic req_t rand_req(input int pct_valid);
      req_t q;
      int   k;
      k    = $urandom_range(0, 4);
      q.v  = ($urandom_range(0, 99) < pct_valid);
      q.op = (k == 4) ? 6'h09 : 6'h00;
      case (k)
         0:       q.fn = 6'h08;
         1:       q.fn = 6'h22;
         2:       q.fn = 6'h24;
         3:       q.fn = 6'h25;
         default: q.fn = 6'h00;
      endcase
      q.a = $urandom;
      q.b = ($urandom_range(0, 3) == 0) ? q.a : $urandom;
      return q;
   endfunction

   initial begin
      rst_n = 1'b0;
      r0_valid = 1'b0; r1_valid = 1'b0; rsp0_ready = 1'b0; rsp1_ready = 1'b0;
      r0_opcode = '0; r0_funct = '0; r0_rs1 = '0; r0_rs2 = '0;
      r1_opcode = '0; r1_funct = '0; r1_rs1 = '0; r1_rs2 = '0;
      m_full = 1'b0; m_owner = 1'b0; m_prio = 1'b0; m_res = '0;
      m_zero = 1'b0; m_ovf = 1'b0; m_cnt = 0;

      // reset, then a single ADD 10+20 on port 0
      do_reset(3);
      step(1'b1, mk(6'h00, 6'h08, 32'd10, 32'd20), IDLE, 1'b1, 1'b1);
      step(1'b1, IDLE, IDLE, 1'b1, 1'b1);
      chk("add_result", exp_q.pop_front(), 32'd30);

      // both requesters valid, responses always consumed: strict alternation
      do_reset(1);
      for (int i = 0; i < 4; i++)
         step(1'b1, mk(6'h00, 6'h08, i, 32'd100), mk(6'h00, 6'h08, i, 32'd200), 1'b1, 1'b1);
      step(1'b1, IDLE, IDLE, 1'b1, 1'b1);

      // SUBI on port 1 held for 3 cycles by back-pressure, then resume
      step(1'b1, IDLE, mk(6'h09, 6'h00, 32'd50, 32'd10), 1'b1, 1'b1);
      for (int i = 0; i < 3; i++)
         step(1'b1, mk(6'h00, 6'h08, 32'd1, 32'd1), mk(6'h09, 6'h00, 32'd7, 32'd2), 1'b1, 1'b0);
      step(1'b1, mk(6'h00, 6'h08, 32'd1, 32'd1), IDLE, 1'b1, 1'b1);
      step(1'b1, IDLE, IDLE, 1'b1, 1'b1);

      // signed overflow on SUB, then zero result
      step(1'b1, mk(6'h00, 6'h22, 32'h8000_0000, 32'd1), IDLE, 1'b1, 1'b1);
      step(1'b1, mk(6'h00, 6'h22, 32'd5, 32'd5), IDLE, 1'b1, 1'b1);
      step(1'b1, IDLE, IDLE, 1'b1, 1'b1);

      // reset while FULL with port 1 waiting
      step(1'b1, IDLE, mk(6'h00, 6'h08, 32'd3, 32'd4), 1'b0, 1'b0);
      step(1'b1, IDLE, mk(6'h00, 6'h08, 32'd3, 32'd4), 1'b0, 1'b0);
      step(1'b0, IDLE, mk(6'h00, 6'h08, 32'd3, 32'd4), 1'b1, 1'b1);
      step(1'b1, IDLE, mk(6'h00, 6'h08, 32'd3, 32'd4), 1'b1, 1'b1);

      // 5 back-to-back accepts: narrow counter wraps
      do_reset(1);
      for (int i = 0; i < 5; i++)
         step(1'b1, mk(6'h00, 6'h08, i, i), IDLE, 1'b1, 1'b1);
      step(1'b1, IDLE, IDLE, 1'b1, 1'b1);

      // random traffic with occasional reset
      for (int i = 0; i < 600; i++) begin
         step(($urandom_range(0, 79) != 0), rand_req(60), rand_req(60),
              ($urandom_range(0, 99) < 70), ($urandom_range(0, 99) < 70));
      end
      step(1'b1, IDLE, IDLE, 1'b1, 1'b1);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
